// File: rtl/fp_mul_pipe.sv
// Pipelined floating-point multiplier: input register, multiply, normalise, round/pack.
// A single advance enable moves the whole pipe at once, so a stalled output freezes every stage.
`timescale 1ns/1ps
module fp_mul_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 15,
    parameter int TAG_W = 4,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_ovf,
    output logic             out_uf
);

    localparam int PW  = 2 * MAN_W + 2;
    localparam int EW2 = EXP_W + 2;
    localparam logic signed [EW2-1:0] BIAS_E  = EW2'((2 ** (EXP_W - 1)) - 1);
    localparam logic signed [EW2-1:0] EXP_MAX = EW2'((2 ** EXP_W) - 1);
    localparam logic signed [EW2-1:0] ZERO_E  = '0;

    logic en;

    logic             s1Valid_q;
    logic [W-1:0]     s1A_q, s1B_q;
    logic [TAG_W-1:0] s1Tag_q;

    logic             s2Valid_q, s2Zero_q, s2Sign_q;
    logic [EXP_W-1:0] s2Ea_q, s2Eb_q;
    logic [PW-1:0]    s2Prod_q;
    logic [TAG_W-1:0] s2Tag_q;

    logic                  s3Valid_q, s3Zero_q, s3Sign_q, s3Guard_q, s3Sticky_q;
    logic signed [EW2-1:0] s3Exp_q;
    logic [MAN_W-1:0]      s3Man_q;
    logic [TAG_W-1:0]      s3Tag_q;

    logic             outValid_q, outOvf_q, outUf_q;
    logic [W-1:0]     outResult_q;
    logic [TAG_W-1:0] outTag_q;

    assign en       = out_ready | ~outValid_q;
    assign in_ready = en;

    logic          s1Zero_d, s1Sign_d;
    logic [PW-1:0] sigA, sigB, s1Prod_d;

    assign s1Zero_d = (s1A_q[W-2:MAN_W] == '0) | (s1B_q[W-2:MAN_W] == '0);
    assign s1Sign_d = s1A_q[W-1] ^ s1B_q[W-1];
    assign sigA     = {{(MAN_W + 1){1'b0}}, 1'b1, s1A_q[MAN_W-1:0]};
    assign sigB     = {{(MAN_W + 1){1'b0}}, 1'b1, s1B_q[MAN_W-1:0]};
    assign s1Prod_d = sigA * sigB;

    logic signed [EW2-1:0] s2ExpBase, s2Exp_d;
    logic [MAN_W-1:0]      s2Man_d;
    logic                  s2Guard_d, s2Sticky_d;

    assign s2ExpBase = $signed({2'b00, s2Ea_q}) + $signed({2'b00, s2Eb_q}) - BIAS_E;

    // A product in [2,4) shifts right one extra place and bumps the exponent.
    always_comb begin
        s2Exp_d    = s2ExpBase;
        s2Man_d    = s2Prod_q[2*MAN_W-1:MAN_W];
        s2Guard_d  = s2Prod_q[MAN_W-1];
        s2Sticky_d = |s2Prod_q[MAN_W-2:0];
        if (s2Prod_q[PW-1]) begin
            s2Exp_d    = s2ExpBase + EW2'(1);
            s2Man_d    = s2Prod_q[2*MAN_W:MAN_W+1];
            s2Guard_d  = s2Prod_q[MAN_W];
            s2Sticky_d = |s2Prod_q[MAN_W-1:0];
        end
    end

    logic                  roundUp;
    logic [MAN_W:0]        manSum;
    logic signed [EW2-1:0] expRnd;
    logic [W-1:0]          result_d;
    logic                  ovf_d, uf_d;

    assign roundUp = s3Guard_q & (s3Sticky_q | s3Man_q[0]);
    assign manSum  = {1'b0, s3Man_q} + {{MAN_W{1'b0}}, roundUp};
    assign expRnd  = s3Exp_q + $signed({{(EW2 - 1){1'b0}}, manSum[MAN_W]});

    // Range check happens after rounding so a round-up carry can still overflow.
    always_comb begin
        result_d = '0;
        ovf_d    = 1'b0;
        uf_d     = 1'b0;
        if (s3Valid_q && !s3Zero_q) begin
            if (expRnd <= ZERO_E) begin
                uf_d = 1'b1;
            end else if (expRnd > EXP_MAX) begin
                result_d = {s3Sign_q, {(W - 1){1'b1}}};
                ovf_d    = 1'b1;
            end else begin
                result_d = {s3Sign_q, expRnd[EXP_W-1:0], manSum[MAN_W-1:0]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1Valid_q   <= 1'b0;
            s1A_q       <= '0;
            s1B_q       <= '0;
            s1Tag_q     <= '0;
            s2Valid_q   <= 1'b0;
            s2Zero_q    <= 1'b0;
            s2Sign_q    <= 1'b0;
            s2Ea_q      <= '0;
            s2Eb_q      <= '0;
            s2Prod_q    <= '0;
            s2Tag_q     <= '0;
            s3Valid_q   <= 1'b0;
            s3Zero_q    <= 1'b0;
            s3Sign_q    <= 1'b0;
            s3Guard_q   <= 1'b0;
            s3Sticky_q  <= 1'b0;
            s3Exp_q     <= '0;
            s3Man_q     <= '0;
            s3Tag_q     <= '0;
            outValid_q  <= 1'b0;
            outResult_q <= '0;
            outTag_q    <= '0;
            outOvf_q    <= 1'b0;
            outUf_q     <= 1'b0;
        end else if (en) begin
            s1Valid_q   <= in_valid & in_ready;
            s1A_q       <= in_a;
            s1B_q       <= in_b;
            s1Tag_q     <= in_tag;
            s2Valid_q   <= s1Valid_q;
            s2Zero_q    <= s1Zero_d;
            s2Sign_q    <= s1Sign_d;
            s2Ea_q      <= s1A_q[W-2:MAN_W];
            s2Eb_q      <= s1B_q[W-2:MAN_W];
            s2Prod_q    <= s1Prod_d;
            s2Tag_q     <= s1Tag_q;
            s3Valid_q   <= s2Valid_q;
            s3Zero_q    <= s2Zero_q;
            s3Sign_q    <= s2Sign_q;
            s3Guard_q   <= s2Guard_d;
            s3Sticky_q  <= s2Sticky_d;
            s3Exp_q     <= s2Exp_d;
            s3Man_q     <= s2Man_d;
            s3Tag_q     <= s2Tag_q;
            outValid_q  <= s3Valid_q;
            outResult_q <= result_d;
            outTag_q    <= s3Valid_q ? s3Tag_q : '0;
            outOvf_q    <= ovf_d;
            outUf_q     <= uf_d;
        end
    end

    assign out_valid  = outValid_q;
    assign out_result = outResult_q;
    assign out_tag    = outTag_q;
    assign out_ovf    = outOvf_q;
    assign out_uf     = outUf_q;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed and streamed checks of fp_mul_pipe with default widths (24-bit word, bias 127).
`timescale 1ns/1ps
module tb_fp_mul_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, out_ovf, out_uf;
    logic [23:0] in_a, in_b, out_result;
    logic [3:0]  in_tag, out_tag;

    int assertCount = 0;
    int failCount   = 0;

    fp_mul_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag),
        .out_ovf(out_ovf), .out_uf(out_uf)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed %h expected %h", name, obs, exp);
        end
    endtask

    // Independent model: round the exact product by remainder comparison against a half-ulp.
    function automatic logic [25:0] modelMul(input logic [23:0] a, input logic [23:0] b);
        longint p, q, rem, half;
        int e, sh;
        logic s;
        logic [7:0] ea, eb;
        ea = a[22:15];
        eb = b[22:15];
        s  = a[23] ^ b[23];
        if (ea == 8'd0 || eb == 8'd0) return 26'd0;
        p  = longint'({1'b1, a[14:0]}) * longint'({1'b1, b[14:0]});
        e  = int'(ea) + int'(eb) - 127;
        sh = 15;
        if (p >= (longint'(1) << 31)) begin
            sh = 16;
            e  = e + 1;
        end
        q    = p >> sh;
        rem  = p - (q << sh);
        half = longint'(1) << (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 1;
        if (q == (longint'(1) << 16)) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e <= 0) return {2'b01, 24'd0};
        if (e > 255) return {2'b10, s, 8'hFF, 15'h7FFF};
        return {2'b00, s, e[7:0], q[14:0]};
    endfunction

    // Accept one pair, then confirm it emerges exactly three edges later.
    task automatic applyStimulus(input string name, input logic [23:0] a, input logic [23:0] b,
                                 input logic [3:0] tag, input logic [23:0] expRes,
                                 input logic expOvf, input logic expUf);
        @(negedge clk);
        in_valid = 1'b1; in_a = a; in_b = b; in_tag = tag; out_ready = 1'b1;
        #1;
        checkOutput({name, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            checkOutput($sformatf("%s_early_valid%0d", name, k), 32'(out_valid), 32'd0);
        end
        @(negedge clk);
        checkOutput({name, "_valid"}, 32'(out_valid), 32'd1);
        checkOutput({name, "_result"}, 32'(out_result), 32'(expRes));
        checkOutput({name, "_tag"}, 32'(out_tag), 32'(tag));
        checkOutput({name, "_ovf"}, 32'(out_ovf), 32'(expOvf));
        checkOutput({name, "_uf"}, 32'(out_uf), 32'(expUf));
    endtask

    logic [23:0] opA [16];
    logic [23:0] opB [16];
    logic [25:0] expQ [$];
    logic [3:0]  tagQ [$];

    initial begin
        logic [25:0] e;
        logic [3:0]  t;
        logic        holdPrev, accepted;
        logic [23:0] holdRes;
        logic [3:0]  holdTag;
        int sent, recv, cycles;

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_result", 32'(out_result), 32'd0);
        checkOutput("rst_tag", 32'(out_tag), 32'd0);
        checkOutput("rst_ovf", 32'(out_ovf), 32'd0);
        checkOutput("rst_uf", 32'(out_uf), 32'd0);

        applyStimulus("mul_1p5sq", 24'h3FC000, 24'h3FC000, 4'd3, 24'h401000, 1'b0, 1'b0);
        applyStimulus("mul_neg3", 24'hC00000, 24'h3FC000, 4'd5, 24'hC04000, 1'b0, 1'b0);
        applyStimulus("mul_zero", 24'h000000, 24'hC04000, 4'd6, 24'h000000, 1'b0, 1'b0);
        applyStimulus("rne_guard0", 24'h3F8001, 24'h3F8001, 4'd7, 24'h3F8002, 1'b0, 1'b0);
        applyStimulus("rne_tie_up", 24'h3F8001, 24'h3FC000, 4'd8, 24'h3FC002, 1'b0, 1'b0);
        applyStimulus("ovf_sat", 24'h7F8000, 24'h7F8000, 4'd10, 24'h7FFFFF, 1'b1, 1'b0);
        applyStimulus("uf_flush", 24'h010000, 24'h010000, 4'd11, 24'h000000, 1'b0, 1'b1);

        for (int i = 0; i < 16; i++) begin
            logic [7:0] ex;
            ex = 8'($urandom_range(100, 155));
            if (i == 4) ex = 8'd0;
            if (i == 7) ex = 8'd250;
            if (i == 10) ex = 8'd3;
            opA[i] = {1'($urandom_range(0, 1)), ex, 15'($urandom)};
            opB[i] = {1'($urandom_range(0, 1)), (i == 4) ? 8'($urandom_range(1, 254)) : ex,
                      15'($urandom)};
        end

        sent = 0; recv = 0; cycles = 0; holdPrev = 1'b0; holdRes = '0; holdTag = '0;
        while (recv < 16 && cycles < 500) begin
            @(negedge clk);
            cycles++;
            if (holdPrev) begin
                checkOutput("stall_valid", 32'(out_valid), 32'd1);
                checkOutput("stall_result", 32'(out_result), 32'(holdRes));
                checkOutput("stall_tag", 32'(out_tag), 32'(holdTag));
            end
            out_ready = 1'($urandom_range(0, 1));
            if (sent < 16) begin
                in_valid = 1'b1; in_a = opA[sent]; in_b = opB[sent]; in_tag = 4'(sent);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            accepted = in_valid & in_ready;
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("stream_extra", 32'(out_valid), 32'd0);
                end else begin
                    e = expQ.pop_front();
                    t = tagQ.pop_front();
                    checkOutput($sformatf("stream%0d_result", recv), 32'(out_result), 32'(e[23:0]));
                    checkOutput($sformatf("stream%0d_flags", recv), 32'({out_ovf, out_uf}), 32'(e[25:24]));
                    checkOutput($sformatf("stream%0d_tag", recv), 32'(out_tag), 32'(t));
                    recv++;
                end
            end
            holdPrev = out_valid & ~out_ready;
            holdRes  = out_result;
            holdTag  = out_tag;
            if (accepted) begin
                expQ.push_back(modelMul(opA[sent], opB[sent]));
                tagQ.push_back(4'(sent));
                sent++;
            end
        end
        checkOutput("stream_received", 32'(recv), 32'd16);
        checkOutput("stream_leftover", 32'(expQ.size()), 32'd0);

        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_a = 24'h3F8000 + 24'(i); in_b = 24'h400000; in_tag = 4'(12 + i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        checkOutput("pre_reset_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_reset_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_reset_result", 32'(out_result), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus("post_reset", 24'h3FC000, 24'h3FC000, 4'd9, 24'h401000, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput($sformatf("post_reset_idle%0d", i), 32'(out_valid), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/fp_mul_pipe.md
# fp_mul_pipe

Pipelined, parametrised floating-point multiplier for the shader datapath, the successor to the combinational 24-bit multiplier. It supports configurable exponent and mantissa widths, round-to-nearest-even, overflow saturation with exception flags, a pass-through tag, and a valid/ready handshake with full backpressure. It sits between the operand-fetch stage and the result writeback arbiter.

## Interface
- EXP_W, 8: exponent field width; bias = 2^(EXP_W-1)-1.
- MAN_W, 15: stored mantissa width; the hidden bit is implicit.
- TAG_W, 4: width of the sideband tag carried alongside each operation.
- Derived: W = 1+EXP_W+MAN_W; the word layout is {sign, exp, mant}.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair present.
- in_ready  out  1  block accepts the operand pair this cycle.
- in_a, in_b  in  W  operands.
- in_tag  in  TAG_W  sideband, returned unchanged with the result.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_result  out  W  product.
- out_tag  out  TAG_W  tag of this result.
- out_ovf  out  1  result saturated due to overflow.
- out_uf  out  1  result flushed to zero due to underflow.

## Operation
- The format has no inf, NaN or denormals. Exponent field 0 means zero, whatever the mantissa. Every other exponent value, including all-ones, is a normal number.
- If either operand is zero, the result is +0 (all bits 0) with both flags clear.
- The sign of a nonzero result is sign_a XOR sign_b.
- Significands are {1, mant}, each MAN_W+1 bits. The product P is 2*MAN_W+2 bits.
- Biased exponent: E = e_a + e_b - bias, computed signed with EXP_W+2 bits.
- Normalisation when P MSB is 1:
  - E = E+1.
  - kept mantissa = P[2*MAN_W:MAN_W+1], guard = P[MAN_W], sticky = OR of P[MAN_W-1:0].
- Normalisation when P MSB is 0:
  - kept mantissa = P[2*MAN_W-1:MAN_W], guard = P[MAN_W-1], sticky = OR of the lower bits.
- Rounding is RNE: increment when guard AND (sticky OR kept lsb). A mantissa carry-out sets the mantissa to 0 and E = E+1.
- Final checks, applied after rounding:
  - E <= 0: result +0, out_uf=1.
  - E > 2^EXP_W-1: result {sign, all-ones exp, all-ones mant}, out_ovf=1.
  - Otherwise: {sign, E[EXP_W-1:0], mantissa}, flags clear.
- The pipeline has three register stages:
  - S1: decode, zero detect, multiply.
  - S2: exponent add, normalise, guard/sticky.
  - S3: round, range check, pack.
- Each stage holds a valid bit. The tag and a zero flag travel with the data.

## Timing
- Reset values: every stage valid = 0; out_valid = 0; out_result, out_tag, out_ovf, out_uf = 0. in_ready = 1 on the first cycle after reset release.
- Global advance enable: en = out_ready OR NOT out_valid. in_ready = en, combinational.
- When en=1, all stages shift by one. S1 captures in_valid AND in_ready. Bubbles propagate and are not collapsed.
- When en=0, all stages, including out_*, hold their values exactly.
- Latency: a pair accepted at edge N appears with out_valid=1 after edge N+3, provided no stall occurs. Each stall cycle adds one cycle of latency.
- Throughput: one result per cycle when in_valid=1 and out_ready=1 are held continuously.
- An accept and a retire in the same cycle are legal and lose no data.
- Assertion of rst_n mid-operation discards all in-flight operations immediately. No partial result is ever presented.
- A producer must hold in_a, in_b and in_tag stable while in_valid=1 and in_ready=0.

## Test plan
All values use defaults (W=24, bias 127).
- 0x3FC000 × 0x3FC000 (1.5×1.5), tag 3 -> 0x401000 (2.25) with tag 3, 3 cycles after accept, flags 0.
- 0xC00000 × 0x3FC000 -> 0xC04000 (-3.0). 0x000000 × 0xC04000 -> 0x000000, flags 0.
- RNE:
  - 0x3F8001 × 0x3F8001 -> 0x3F8002 (guard 0).
  - 0x3F8001 × 0x3FC000 -> 0x3FC002 (tie, lsb 1, rounds up).
- 0x7F8000 × 0x7F8000 -> 0x7FFFFF, out_ovf=1. 0x010000 × 0x010000 -> 0x000000, out_uf=1.
- Stream 16 random pairs at in_valid=1 while toggling out_ready pseudo-randomly -> results match the model in order with matching tags, nothing dropped or duplicated, and outputs stable while out_ready=0.
- Pull rst_n low with 3 operations in flight -> out_valid=0 immediately. After release, the next accepted pair yields only its own result.
